// File: rtl/multicycle_control.sv
// Multi-cycle RV32I controller: sequences fetch/decode/execute/memory/writeback on a shared
// datapath, stalls on mem_ready, traps on illegal opcodes or bus timeout, counts retirements.
module multicycle_control #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  opcode,
  input  logic        mem_ready,
  input  logic        branch_cond,
  output logic        PCWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        MemToReg,
  output logic        IorD,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUOp,
  output logic        PCSrc,
  output logic [3:0]  state,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [31:0] instret
);

  typedef enum logic [3:0] {
    StIdle    = 4'd0,
    StFetch   = 4'd1,
    StDecode  = 4'd2,
    StExecR   = 4'd3,
    StExecI   = 4'd4,
    StAluWb   = 4'd5,
    StMemAddr = 4'd6,
    StMemRd   = 4'd7,
    StMemWb   = 4'd8,
    StMemWr   = 4'd9,
    StBranch  = 4'd10,
    StTrap    = 4'd15
  } state_e;

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;

  localparam logic [1:0] CauseNone    = 2'b00;
  localparam logic [1:0] CauseIllegal = 2'b01;
  localparam logic [1:0] CauseBus     = 2'b10;

  // Keep at least one bit so TIMEOUT=0 still elaborates; the compare is then disabled.
  localparam int unsigned CntW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = (TIMEOUT == 0) ? '0 : CntW'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [CntW-1:0]   wait_q, wait_d;
  logic [1:0]        cause_q, cause_d;
  logic [31:0]       instret_q;
  logic              retire;
  logic              timed_out;

  assign timed_out = (TIMEOUT != 0) && (wait_q == CntLast) && !mem_ready;

  // Next state; wait_d defaults to zero so the counter clears on entry and on mem_ready.
  always_comb begin
    state_d = state_q;
    wait_d  = '0;
    cause_d = cause_q;
    retire  = 1'b0;
    case (state_q)
      StIdle: state_d = StFetch;
      StFetch, StMemRd, StMemWr: begin
        if (mem_ready) begin
          if (state_q == StFetch) begin
            state_d = StDecode;
          end else if (state_q == StMemRd) begin
            state_d = StMemWb;
          end else begin
            state_d = StFetch;
            retire  = 1'b1;
          end
        end else if (timed_out) begin
          state_d = StTrap;
          cause_d = CauseBus;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StDecode: begin
        case (opcode)
          OpR:             state_d = StExecR;
          OpImm:           state_d = StExecI;
          OpLoad, OpStore: state_d = StMemAddr;
          OpBranch:        state_d = StBranch;
          default: begin
            state_d = StTrap;
            cause_d = CauseIllegal;
          end
        endcase
      end
      StExecR, StExecI: state_d = StAluWb;
      StMemAddr:        state_d = (opcode == OpLoad) ? StMemRd : StMemWr;
      StAluWb, StMemWb, StBranch: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
      StTrap:  state_d = StTrap;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    PCWrite  = 1'b0;
    IRWrite  = 1'b0;
    RegWrite = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    MemToReg = 1'b0;
    IorD     = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    ALUOp    = 2'b00;
    PCSrc    = 1'b0;
    case (state_q)
      StFetch: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      StDecode: ALUSrcB = 2'b10;
      StExecR: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      StExecI: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = 2'b10;
      end
      StAluWb: RegWrite = 1'b1;
      StMemAddr: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      StMemRd: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      StMemWb: begin
        RegWrite = 1'b1;
        MemToReg = 1'b1;
      end
      StMemWr: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      StBranch: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b01;
        PCSrc   = 1'b1;
        PCWrite = branch_cond;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      wait_q    <= '0;
      cause_q   <= CauseNone;
      instret_q <= 32'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cause_q <= cause_d;
      if (retire) begin
        instret_q <= instret_q + 32'd1;
      end
    end
  end

  assign state      = state_q;
  assign trap       = (state_q == StTrap);
  assign trap_cause = cause_q;
  assign instret    = instret_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle state and control-bus checks against
// hand-derived vectors, covering stalls, branches, traps, timeout boundary and async reset.
module tb_multicycle_control;

  logic        clk;
  logic        rst_n;
  logic [6:0]  opcode;
  logic        mem_ready;
  logic        branch_cond;
  logic        PCWrite, IRWrite, RegWrite, MemRead, MemWrite, MemToReg, IorD, ALUSrcA, PCSrc;
  logic [1:0]  ALUSrcB, ALUOp;
  logic [3:0]  state;
  logic        trap;
  logic [1:0]  trap_cause;
  logic [31:0] instret;
  logic [12:0] ctrl;

  int n_cmp;
  int n_err;

  multicycle_control #(.TIMEOUT(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .mem_ready  (mem_ready),
    .branch_cond(branch_cond),
    .PCWrite    (PCWrite),
    .IRWrite    (IRWrite),
    .RegWrite   (RegWrite),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .MemToReg   (MemToReg),
    .IorD       (IorD),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUOp      (ALUOp),
    .PCSrc      (PCSrc),
    .state      (state),
    .trap       (trap),
    .trap_cause (trap_cause),
    .instret    (instret)
  );

  // {PCWrite,IRWrite,RegWrite,MemRead,MemWrite,MemToReg,IorD,ALUSrcA,ALUSrcB,ALUOp,PCSrc}
  assign ctrl = {PCWrite, IRWrite, RegWrite, MemRead, MemWrite, MemToReg, IorD, ALUSrcA,
                 ALUSrcB, ALUOp, PCSrc};

  localparam logic [12:0] CNone     = 13'b0_0_0_0_0_0_0_0_00_00_0;
  localparam logic [12:0] CFetchRdy = 13'b1_1_0_1_0_0_0_0_01_00_0;
  localparam logic [12:0] CFetchW   = 13'b0_0_0_1_0_0_0_0_01_00_0;
  localparam logic [12:0] CDecode   = 13'b0_0_0_0_0_0_0_0_10_00_0;
  localparam logic [12:0] CExecR    = 13'b0_0_0_0_0_0_0_1_00_10_0;
  localparam logic [12:0] CExecI    = 13'b0_0_0_0_0_0_0_1_10_10_0;
  localparam logic [12:0] CAluWb    = 13'b0_0_1_0_0_0_0_0_00_00_0;
  localparam logic [12:0] CMemAddr  = 13'b0_0_0_0_0_0_0_1_10_00_0;
  localparam logic [12:0] CMemRd    = 13'b0_0_0_1_0_0_1_0_00_00_0;
  localparam logic [12:0] CMemWb    = 13'b0_0_1_0_0_1_0_0_00_00_0;
  localparam logic [12:0] CMemWr    = 13'b0_0_0_0_1_0_1_0_00_00_0;
  localparam logic [12:0] CBrTaken  = 13'b1_0_0_0_0_0_0_1_00_01_1;
  localparam logic [12:0] CBrNot    = 13'b0_0_0_0_0_0_0_1_00_01_1;

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpBad    = 7'b1111111;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at posedge+1: drive this cycle's inputs, check state/controls, advance one clock.
  task automatic cyc(input string tag, input logic mr, input logic bc, input logic [3:0] es,
                     input logic [12:0] ec);
    mem_ready   = mr;
    branch_cond = bc;
    #1;
    check({tag, "_state"}, 32'(state), 32'(es));
    check({tag, "_ctrl"}, 32'(ctrl), 32'(ec));
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse(input string tag);
    rst_n = 1'b0;
    #1;
    check({tag, "_rst_state"}, 32'(state), 32'd0);
    check({tag, "_rst_ctrl"}, 32'(ctrl), 32'(CNone));
    check({tag, "_rst_instret"}, instret, 32'd0);
    check({tag, "_rst_trap"}, 32'({trap, trap_cause}), 32'd0);
    @(posedge clk);
    #1;
    check({tag, "_rst_hold"}, 32'(state), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp       = 0;
    n_err       = 0;
    rst_n       = 1'b0;
    opcode      = OpR;
    mem_ready   = 1'b1;
    branch_cond = 1'b0;
    #2;
    check("reset_state", 32'(state), 32'd0);
    check("reset_ctrl", 32'(ctrl), 32'(CNone));
    check("reset_trap", 32'({trap, trap_cause}), 32'd0);
    check("reset_instret", instret, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("idle_after_release", 32'(state), 32'd0);
    @(posedge clk);
    #1;

    // ADD, no stalls: 1,2,3,5 then back to FETCH
    opcode = OpR;
    cyc("add_f", 1'b1, 1'b0, 4'd1, CFetchRdy);
    cyc("add_d", 1'b1, 1'b0, 4'd2, CDecode);
    cyc("add_x", 1'b1, 1'b0, 4'd3, CExecR);
    cyc("add_wb", 1'b1, 1'b0, 4'd5, CAluWb);
    check("add_instret", instret, 32'd1);

    // ADDI, mem_ready low outside wait states must be ignored
    opcode = OpImm;
    cyc("addi_f", 1'b1, 1'b0, 4'd1, CFetchRdy);
    cyc("addi_d", 1'b0, 1'b0, 4'd2, CDecode);
    cyc("addi_x", 1'b0, 1'b0, 4'd4, CExecI);
    cyc("addi_wb", 1'b0, 1'b0, 4'd5, CAluWb);
    check("addi_instret", instret, 32'd2);

    // LW: 3 fetch waits, 2 read waits -> 10 cycles
    opcode = OpLoad;
    for (int i = 0; i < 3; i++) cyc("lw_fw", 1'b0, 1'b0, 4'd1, CFetchW);
    cyc("lw_f", 1'b1, 1'b0, 4'd1, CFetchRdy);
    cyc("lw_d", 1'b1, 1'b0, 4'd2, CDecode);
    cyc("lw_a", 1'b1, 1'b0, 4'd6, CMemAddr);
    for (int i = 0; i < 2; i++) cyc("lw_rw", 1'b0, 1'b0, 4'd7, CMemRd);
    cyc("lw_r", 1'b1, 1'b0, 4'd7, CMemRd);
    cyc("lw_wb", 1'b1, 1'b0, 4'd8, CMemWb);
    check("lw_next_fetch", 32'(state), 32'd1);
    check("lw_instret", instret, 32'd3);

    // SW with one write wait
    opcode = OpStore;
    cyc("sw_f", 1'b1, 1'b0, 4'd1, CFetchRdy);
    cyc("sw_d", 1'b1, 1'b0, 4'd2, CDecode);
    cyc("sw_a", 1'b1, 1'b0, 4'd6, CMemAddr);
    cyc("sw_ww", 1'b0, 1'b0, 4'd9, CMemWr);
    check("sw_no_retire_yet", instret, 32'd3);
    cyc("sw_w", 1'b1, 1'b0, 4'd9, CMemWr);
    check("sw_instret", instret, 32'd4);

    // BEQ taken then not taken, 3 cycles each
    opcode = OpBranch;
    cyc("beq1_f", 1'b1, 1'b1, 4'd1, CFetchRdy);
    cyc("beq1_d", 1'b1, 1'b1, 4'd2, CDecode);
    cyc("beq1_b", 1'b1, 1'b1, 4'd10, CBrTaken);
    check("beq1_next", 32'(state), 32'd1);
    cyc("beq0_f", 1'b1, 1'b0, 4'd1, CFetchRdy);
    cyc("beq0_d", 1'b1, 1'b0, 4'd2, CDecode);
    cyc("beq0_b", 1'b1, 1'b0, 4'd10, CBrNot);
    check("beq_instret", instret, 32'd6);

    // Store timeout: exactly 16 wait cycles then TRAP cause 10
    opcode = OpStore;
    cyc("swto_f", 1'b1, 1'b0, 4'd1, CFetchRdy);
    cyc("swto_d", 1'b1, 1'b0, 4'd2, CDecode);
    cyc("swto_a", 1'b1, 1'b0, 4'd6, CMemAddr);
    for (int i = 0; i < 16; i++) cyc("swto_w", 1'b0, 1'b0, 4'd9, CMemWr);
    check("swto_state", 32'(state), 32'd15);
    check("swto_trap", 32'(trap), 32'd1);
    check("swto_cause", 32'(trap_cause), 32'd2);
    check("swto_ctrl", 32'(ctrl), 32'(CNone));
    check("swto_instret", instret, 32'd6);
    reset_pulse("r1");

    // mem_ready on the 16th wait cycle wins over the timeout
    cyc("swok_f", 1'b1, 1'b0, 4'd1, CFetchRdy);
    cyc("swok_d", 1'b1, 1'b0, 4'd2, CDecode);
    cyc("swok_a", 1'b1, 1'b0, 4'd6, CMemAddr);
    for (int i = 0; i < 15; i++) cyc("swok_w", 1'b0, 1'b0, 4'd9, CMemWr);
    cyc("swok_last", 1'b1, 1'b0, 4'd9, CMemWr);
    check("swok_state", 32'(state), 32'd1);
    check("swok_trap", 32'({trap, trap_cause}), 32'd0);
    check("swok_instret", instret, 32'd1);

    // Illegal opcode traps and stays put for 20 cycles
    opcode = OpBad;
    cyc("ill_f", 1'b1, 1'b0, 4'd1, CFetchRdy);
    cyc("ill_d", 1'b1, 1'b0, 4'd2, CDecode);
    check("ill_trap", 32'(trap), 32'd1);
    check("ill_cause", 32'(trap_cause), 32'd1);
    for (int i = 0; i < 20; i++) begin
      cyc("ill_hold", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'd15, CNone);
    end
    check("ill_cause_held", 32'(trap_cause), 32'd1);
    check("ill_instret", instret, 32'd1);
    reset_pulse("r2");

    // ADD, then LW aborted by reset in MEM_WB
    opcode = OpR;
    cyc("add2_f", 1'b1, 1'b0, 4'd1, CFetchRdy);
    cyc("add2_d", 1'b1, 1'b0, 4'd2, CDecode);
    cyc("add2_x", 1'b1, 1'b0, 4'd3, CExecR);
    cyc("add2_wb", 1'b1, 1'b0, 4'd5, CAluWb);
    opcode = OpLoad;
    cyc("lw2_f", 1'b1, 1'b0, 4'd1, CFetchRdy);
    cyc("lw2_d", 1'b1, 1'b0, 4'd2, CDecode);
    cyc("lw2_a", 1'b1, 1'b0, 4'd6, CMemAddr);
    cyc("lw2_r", 1'b1, 1'b0, 4'd7, CMemRd);
    #1;
    check("lw2_in_wb", 32'(ctrl), 32'(CMemWb));
    check("lw2_instret_before", instret, 32'd1);
    reset_pulse("r3");
    check("after_r3_fetch", 32'(state), 32'd1);
    check("after_r3_instret", instret, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
